// File: rtl/spi_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_regs_pkg
// Brief  : Frame geometry, register map and controller state encoding
// Rev    : 1.0
// ============================================================================
package spi_regs_pkg;

  localparam int         FRAME_W          = 16;
  localparam logic       RW_WRITE         = 1'b1;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module : spi_clk_div
// Brief  : Half-period tick generator for SCLK; restarts after each tick
// Rev    : 1.0
// ============================================================================
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module : spi_controller
// Brief  : SPI mode-0 write-only initiator, one 16-bit frame per accepted request
// Rev    : 1.0
// ============================================================================
module spi_controller
  import spi_regs_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS,
  output logic       busy,
  output logic       done
);

  localparam int PH_MAX = (CS_SETUP > CS_HOLD) ?
                          ((CS_SETUP > IDLE_GAP) ? CS_SETUP : IDLE_GAP) :
                          ((CS_HOLD  > IDLE_GAP) ? CS_HOLD  : IDLE_GAP);
  localparam int            PH_W       = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(CS_HOLD - 1);
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(IDLE_GAP - 1);
  localparam logic [3:0]      BIT_LAST   = 4'(FRAME_W - 1);

  spi_state_e           state_q, state_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [3:0]           bit_q, bit_d;
  logic [FRAME_W-1:0]   sh_q, sh_d;
  logic                 sclk_q, sclk_d;
  logic                 ncs_q, ncs_d;
  logic                 done_q, done_d;
  logic                 tick;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ST_SHIFT),
    .clr   (state_q != ST_SHIFT),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          sh_d    = {req_rw, req_addr, req_data};
          ncs_d   = 1'b0;
          sclk_d  = 1'b0;
          bit_d   = '0;
          ph_d    = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (ph_q == SETUP_LAST) begin
          ph_d    = '0;
          state_d = ST_SHIFT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Data moves on the falling edge so COPI is settled before the next rise.
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = ST_HOLD;
            end else begin
              bit_d = bit_q + 1'b1;
              sh_d  = {sh_q[FRAME_W-2:0], 1'b0};
            end
          end
        end
      end
      ST_HOLD: begin
        if (ph_q == HOLD_LAST) begin
          ph_d    = '0;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          sh_d    = '0;
          state_d = ST_GAP;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (ph_q == GAP_LAST) begin
          ph_d    = '0;
          state_d = ST_IDLE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ncs_d   = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      done_q  <= done_d;
    end
  end

  assign SCLK      = sclk_q;
  assign COPI      = sh_q[FRAME_W-1];
  assign nCS       = ncs_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign req_ready = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_controller
// Brief  : Drives two controller configurations and decodes their pins as a peripheral
// Rev    : 1.0
// ============================================================================
module tb_spi_controller;
  import spi_regs_pkg::*;

  // Accept-to-accept period and nCS-high run between back-to-back frames
  localparam int PER_A = 1 + 2 + 32 * 4 + 2 + 4;
  localparam int PER_B = 1 + 1 + 32 * 2 + 1 + 1;
  localparam int GAP_A = 4 + 1;
  localparam int GAP_B = 1 + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r_valid [2];
  logic       r_rw    [2];
  logic [6:0] r_addr  [2];
  logic [7:0] r_data  [2];
  wire  [1:0] m_rdy, m_sclk, m_copi, m_ncs, m_busy, m_done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_controller u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r_valid[0]), .req_ready(m_rdy[0]),
    .req_rw(r_rw[0]), .req_addr(r_addr[0]), .req_data(r_data[0]),
    .SCLK(m_sclk[0]), .COPI(m_copi[0]), .nCS(m_ncs[0]),
    .busy(m_busy[0]), .done(m_done[0])
  );

  spi_controller #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .IDLE_GAP(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r_valid[1]), .req_ready(m_rdy[1]),
    .req_rw(r_rw[1]), .req_addr(r_addr[1]), .req_data(r_data[1]),
    .SCLK(m_sclk[1]), .COPI(m_copi[1]), .nCS(m_ncs[1]),
    .busy(m_busy[1]), .done(m_done[1])
  );

  // Pin-level receiver state, one slot per DUT
  logic        p_sclk [2] = '{1'b0, 1'b0};
  logic        p_copi [2] = '{1'b0, 1'b0};
  logic        p_ncs  [2] = '{1'b1, 1'b1};
  bit          in_fr  [2];
  logic [15:0] shr    [2];
  int cur_rises [2] = '{0, 0};
  int hi_run    [2] = '{0, 0};
  int last_gap  [2] = '{0, 0};
  int copi_bad  [2] = '{0, 0};
  int done_cnt  [2] = '{0, 0};
  int done_bad  [2] = '{0, 0};
  int ndone_exp [2] = '{0, 0};
  logic [15:0] fq0 [$], fq1 [$], eq0 [$], eq1 [$];
  int          rq0 [$], rq1 [$];
  logic [7:0]  periph  [128] = '{default: 8'h00};
  logic [7:0]  exp_reg [128] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        in_fr[d]  = 1'b0;
        hi_run[d] = 0;
      end else begin
        if (m_sclk[d] && (m_copi[d] !== p_copi[d])) copi_bad[d]++;
        if (m_sclk[d] && !p_sclk[d]) begin
          shr[d] = {shr[d][14:0], m_copi[d]};
          cur_rises[d]++;
        end
        if (!m_ncs[d] && p_ncs[d]) begin
          in_fr[d]     = 1'b1;
          cur_rises[d] = 0;
          last_gap[d]  = hi_run[d];
        end
        if (m_done[d]) begin
          done_cnt[d]++;
          if (!(m_ncs[d] && !p_ncs[d])) done_bad[d]++;
        end
        if (m_ncs[d] && !p_ncs[d] && in_fr[d]) begin
          in_fr[d] = 1'b0;
          if (d == 0) begin
            fq0.push_back(shr[d]);
            rq0.push_back(cur_rises[d]);
            if (shr[d][15] == RW_WRITE) periph[shr[d][14:8]] = shr[d][7:0];
          end else begin
            fq1.push_back(shr[d]);
            rq1.push_back(cur_rises[d]);
          end
        end
        hi_run[d] = m_ncs[d] ? hi_run[d] + 1 : 0;
      end
      p_sclk[d] = m_sclk[d];
      p_copi[d] = m_copi[d];
      p_ncs[d]  = m_ncs[d];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [15:0] f, input bit hold, output int t);
    int n = 0;
    r_valid[d] = 1'b1;
    r_rw[d]    = f[15];
    r_addr[d]  = f[14:8];
    r_data[d]  = f[7:0];
    while (m_rdy[d] !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk("accept_wait", 32'(m_rdy[d]), 32'd1);
    t = cyc;
    if (d == 0) eq0.push_back(f); else eq1.push_back(f);
    step();
    if (!hold) r_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (!(m_rdy[d] === 1'b1 && m_ncs[d] === 1'b1) && n < 400) begin
      step();
      n++;
    end
    chk("idle_wait", 32'(m_rdy[d]), 32'd1);
  endtask

  task automatic check_frames(input int d, input int n);
    logic [15:0] got, exp;
    int r;
    chk("frame_count", 32'((d == 0) ? fq0.size() : fq1.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = 16'hxxxx; exp = 16'h0000; r = 0;
      if (d == 0 && fq0.size() > 0 && eq0.size() > 0) begin
        got = fq0.pop_front(); exp = eq0.pop_front(); r = rq0.pop_front();
      end else if (d == 1 && fq1.size() > 0 && eq1.size() > 0) begin
        got = fq1.pop_front(); exp = eq1.pop_front(); r = rq1.pop_front();
      end
      chk("frame_bits", 32'(got), 32'(exp));
      chk("rise_count", 32'(r), 32'd16);
      if (d == 0) begin
        if (exp[15] == RW_WRITE) exp_reg[exp[14:8]] = exp[7:0];
        chk("periph_reg", 32'(periph[exp[14:8]]), 32'(exp_reg[exp[14:8]]));
      end
    end
    ndone_exp[d] += n;
    fq0.delete(); fq1.delete(); eq0.delete(); eq1.delete(); rq0.delete(); rq1.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, n;
    logic [15:0] f;
    for (int d = 0; d < 2; d++) begin
      r_valid[d] = 1'b0; r_rw[d] = 1'b0; r_addr[d] = '0; r_data[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_sclk",  32'(m_sclk[d]), 32'd0);
      chk("rst_copi",  32'(m_copi[d]), 32'd0);
      chk("rst_ncs",   32'(m_ncs[d]),  32'd1);
      chk("rst_busy",  32'(m_busy[d]), 32'd0);
      chk("rst_done",  32'(m_done[d]), 32'd0);
      chk("rst_ready", 32'(m_rdy[d]),  32'd1);
    end

    // Single write frame
    send(0, {RW_WRITE, ADDR_EN_OUT_7_0, 8'hF0}, 1'b0, t1);
    wait_idle(0);
    check_frames(0, 1);
    chk("sclk_idle", 32'(m_sclk[0]), 32'd0);
    chk("done_once", 32'(done_cnt[0]), 32'(ndone_exp[0]));

    // Held request: two frames back-to-back
    send(0, {RW_WRITE, ADDR_PWM_DUTY, 8'h80}, 1'b1, t1);
    send(0, {RW_WRITE, ADDR_EN_PWM_7_0, 8'h01}, 1'b0, t2);
    chk("period_a", 32'(t2 - t1), 32'(PER_A));
    wait_idle(0);
    chk("gap_a", 32'(last_gap[0]), 32'(GAP_A));
    check_frames(0, 2);

    // Random frames with a conflicting request pulsed mid-frame
    for (int i = 0; i < 6; i++) begin
      f = 16'($urandom);
      send(0, f, 1'b0, t1);
      repeat ($urandom_range(5, 100)) step();
      r_valid[0] = 1'b1; r_rw[0] = ~f[15]; r_addr[0] = ~f[14:8]; r_data[0] = ~f[7:0];
      step();
      r_valid[0] = 1'b0;
      wait_idle(0);
      repeat (3) step();
      chk("no_spurious", 32'(m_busy[0]), 32'd0);
      check_frames(0, 1);
    end

    // Reset after the seventh rise
    f = 16'($urandom) | 16'h8000;
    send(0, f, 1'b0, t1);
    n = 0;
    while (!(in_fr[0] && cur_rises[0] == 7) && n < 400) begin
      step();
      n++;
    end
    chk("rise7_wait", 32'(cur_rises[0]), 32'd7);
    n = done_cnt[0];
    rst_n = 1'b0;
    #1;
    chk("rst_ncs_now",  32'(m_ncs[0]),  32'd1);
    chk("rst_sclk_now", 32'(m_sclk[0]), 32'd0);
    repeat (3) step();
    chk("rst_no_done", 32'(done_cnt[0]), 32'(n));
    chk("rst_no_frame", 32'(fq0.size()), 32'd0);
    eq0.delete();
    rst_n = 1'b1;
    step();
    send(0, 16'($urandom), 1'b0, t1);
    wait_idle(0);
    check_frames(0, 1);

    // Loopback into the register model
    send(0, {RW_WRITE, ADDR_EN_OUT_7_0, 8'hFF}, 1'b0, t1);
    send(0, {RW_WRITE, ADDR_EN_PWM_7_0, 8'hFF}, 1'b0, t1);
    send(0, {RW_WRITE, ADDR_PWM_DUTY, 8'h80}, 1'b0, t1);
    send(0, {1'b0, ADDR_EN_OUT_15_8, 8'($urandom)}, 1'b0, t1);
    wait_idle(0);
    check_frames(0, 4);
    chk("lb_en_out", 32'(periph[ADDR_EN_OUT_7_0]), 32'h0000_00FF);
    chk("lb_en_pwm", 32'(periph[ADDR_EN_PWM_7_0]), 32'h0000_00FF);
    chk("lb_duty",   32'(periph[ADDR_PWM_DUTY]),   32'h0000_0080);
    chk("lb_read_ignored", 32'(periph[ADDR_EN_OUT_15_8]), 32'(exp_reg[ADDR_EN_OUT_15_8]));

    // Fastest legal configuration
    send(1, 16'($urandom), 1'b1, t1);
    send(1, 16'($urandom), 1'b0, t2);
    chk("period_b", 32'(t2 - t1), 32'(PER_B));
    wait_idle(1);
    chk("gap_b", 32'(last_gap[1]), 32'(GAP_B));
    check_frames(1, 2);

    for (int d = 0; d < 2; d++) begin
      chk("copi_stable", 32'(copi_bad[d]), 32'd0);
      chk("done_align",  32'(done_bad[d]), 32'd0);
      chk("done_total",  32'(done_cnt[d]), 32'(ndone_exp[d]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
